// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues request-to-send,
// shifts one byte plus odd parity and stop on device clock edges, then checks the ACK.
module ps2_host_tx_ctrl #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic       rx_busy,
    output logic       rx_enable,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INHIBIT = 3'd1;
    localparam logic [2:0] ST_RTS     = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    logic [1:0] raw_lines;
    logic [1:0] filt_lines;
    assign raw_lines = {ps2d_in, ps2c_in};

    // Bit 0 is PS2C, bit 1 is PS2D; both idle high through reset.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic           sync1_reg;
            logic           sync2_reg;
            logic           filt_reg;
            logic [FCW-1:0] stab_cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg    <= 1'b1;
                    sync2_reg    <= 1'b1;
                    filt_reg     <= 1'b1;
                    stab_cnt_reg <= '0;
                end else begin
                    sync1_reg <= raw_lines[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == filt_reg) begin
                        stab_cnt_reg <= '0;
                    end else if (stab_cnt_reg == FCW'(FILTER_LEN - 1)) begin
                        filt_reg     <= sync2_reg;
                        stab_cnt_reg <= '0;
                    end else begin
                        stab_cnt_reg <= stab_cnt_reg + 1'b1;
                    end
                end
            end

            assign filt_lines[gi] = filt_reg;
        end
    endgenerate

    logic filt_c;
    logic filt_d;
    logic filt_c_prev_reg;
    logic c_fall;
    assign filt_c = filt_lines[0];
    assign filt_d = filt_lines[1];
    assign c_fall = filt_c_prev_reg & ~filt_c;

    logic [2:0]     state_reg;
    logic [ICW-1:0] inh_cnt_reg;
    logic [TCW-1:0] tmo_cnt_reg;
    logic [3:0]     edge_cnt_reg;
    logic [9:0]     frame_reg;
    logic           ps2c_oe_reg;
    logic           ps2d_oe_reg;
    logic           rx_enable_reg;
    logic           done_reg;
    logic           err_reg;
    logic [1:0]     err_code_reg;
    logic           tmo_hit;

    assign tmo_hit   = (tmo_cnt_reg >= TCW'(TIMEOUT_CYCLES - 1));
    assign cmd_ready = (state_reg == ST_IDLE) && !rx_busy;
    assign ps2c_oe   = ps2c_oe_reg;
    assign ps2d_oe   = ps2d_oe_reg;
    assign rx_enable = rx_enable_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            inh_cnt_reg     <= '0;
            tmo_cnt_reg     <= '0;
            edge_cnt_reg    <= '0;
            frame_reg       <= '0;
            ps2c_oe_reg     <= 1'b0;
            ps2d_oe_reg     <= 1'b0;
            rx_enable_reg   <= 1'b1;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            err_code_reg    <= 2'b00;
            filt_c_prev_reg <= 1'b1;
        end else begin
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            filt_c_prev_reg <= filt_c;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        frame_reg     <= {1'b1, ~^cmd_data, cmd_data};
                        err_code_reg  <= 2'b00;
                        rx_enable_reg <= 1'b0;
                        ps2c_oe_reg   <= 1'b1;
                        inh_cnt_reg   <= '0;
                        state_reg     <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt_reg == ICW'(INHIBIT_CYCLES - 1)) begin
                        ps2d_oe_reg <= 1'b1;
                        state_reg   <= ST_RTS;
                    end else begin
                        inh_cnt_reg <= inh_cnt_reg + 1'b1;
                    end
                end
                ST_RTS: begin
                    ps2c_oe_reg  <= 1'b0;
                    tmo_cnt_reg  <= '0;
                    edge_cnt_reg <= '0;
                    state_reg    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tmo_hit) begin
                        err_reg       <= 1'b1;
                        err_code_reg  <= 2'b10;
                        ps2c_oe_reg   <= 1'b0;
                        ps2d_oe_reg   <= 1'b0;
                        rx_enable_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        // Edge n presents frame bit n-1; the stop bit releases PS2D.
                        if (c_fall) begin
                            ps2d_oe_reg  <= ~frame_reg[edge_cnt_reg];
                            edge_cnt_reg <= edge_cnt_reg + 1'b1;
                            if (edge_cnt_reg == 4'd9) begin
                                state_reg <= ST_ACK;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    if (c_fall) begin
                        if (!filt_d) begin
                            state_reg <= ST_RELEASE;
                        end else begin
                            err_reg       <= 1'b1;
                            err_code_reg  <= 2'b01;
                            rx_enable_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        err_reg       <= 1'b1;
                        err_code_reg  <= 2'b10;
                        ps2c_oe_reg   <= 1'b0;
                        ps2d_oe_reg   <= 1'b0;
                        rx_enable_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (filt_c && filt_d) begin
                        done_reg      <= 1'b1;
                        rx_enable_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Bench for ps2_host_tx_ctrl: open-drain line model plus a behavioural PS/2 device that
// clocks frames, records the bits it samples and optionally ACKs.
module tb_ps2_host_tx_ctrl;

    localparam int INH = 40;
    localparam int FL  = 8;
    localparam int TMO = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_busy = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       dev_c = 1'b1;
    logic       dev_d = 1'b1;
    logic       glitch_c = 1'b0;
    logic       ps2c_line;
    logic       ps2d_line;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       rx_enable;
    logic       cmd_ready;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    assign ps2c_line = ~ps2c_oe & dev_c & ~glitch_c;
    assign ps2d_line = ~ps2d_oe & dev_d;

    ps2_host_tx_ctrl #(
        .INHIBIT_CYCLES(INH),
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2c_in  (ps2c_line),
        .ps2d_in  (ps2d_line),
        .ps2c_oe  (ps2c_oe),
        .ps2d_oe  (ps2d_oe),
        .rx_busy  (rx_busy),
        .rx_enable(rx_enable),
        .cmd_valid(cmd_valid),
        .cmd_data (cmd_data),
        .cmd_ready(cmd_ready),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    end

    typedef struct {
        logic [7:0] cmd;
        bit         ack;
        bit         glitch;
        logic [1:0] exp_code;
        bit         exp_done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // What the device should see: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_bits(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic measure_inhibit();
        int c = 0;
        int dcnt = 0;
        while (ps2c_oe === 1'b1 && c < INH + 50) begin
            c++;
            if (ps2d_oe === 1'b1) dcnt++;
            @(negedge clk);
        end
        check("inhibit_plus_rts_cycles", c, INH + 1);
        check("rts_cycles_with_ps2d_low", dcnt, 1);
    endtask

    task automatic accept(input logic [7:0] d);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        #1 check("cmd_ready_at_offer", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rx_enable_low_after_accept", rx_enable, 0);
        check("ps2c_oe_high_after_accept", ps2c_oe, 1);
        measure_inhibit();
    endtask

    task automatic device(input int n_edges, input bit ack, input bit glitch, output logic [10:0] bits);
        bits = '0;
        for (int i = 0; i < n_edges; i++) begin
            if (glitch && i >= 2 && i <= 7) begin
                repeat (4) @(negedge clk);
                glitch_c = 1'b1;
                repeat (3) @(negedge clk);
                glitch_c = 1'b0;
                repeat (8) @(negedge clk);
            end else begin
                repeat (15) @(negedge clk);
            end
            bits[i] = ps2d_line;
            if (i == 10 && ack) dev_d = 1'b0;
            repeat (15) @(negedge clk);
            dev_c = 1'b0;
            repeat (30) @(negedge clk);
            dev_c = 1'b1;
        end
        repeat (5) @(negedge clk);
        dev_d = 1'b1;
    endtask

    task automatic finish_frame(input vec_t v);
        logic [10:0] bits;
        int d0, e0, w;
        d0 = done_cnt;
        e0 = err_cnt;
        device(11, v.ack, v.glitch, bits);
        w = 0;
        while (done_cnt + err_cnt == d0 + e0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("outcome_within_bound", (w < 200), 1);
        repeat (3) @(negedge clk);
        check("device_sampled_bits", bits, model_bits(v.cmd));
        check("done_pulses", done_cnt - d0, v.exp_done ? 1 : 0);
        check("err_pulses", err_cnt - e0, v.exp_done ? 0 : 1);
        check("err_code", err_code, v.exp_code);
        check("oe_released", {ps2c_oe, ps2d_oe}, 2'b00);
        check("rx_enable_restored", rx_enable, 1);
        check("cmd_ready_restored", cmd_ready, 1);
        $display("[TB] frame cmd=%02h ack=%0d glitch=%0d bits=%03h done=%0d err=%0d code=%0d",
                 v.cmd, v.ack, v.glitch, bits, done_cnt - d0, err_cnt - e0, err_code);
    endtask

    vec_t vecs[9];

    initial begin
        logic [10:0] bits;
        int k, bad, e0;

        vecs[0] = '{cmd: 8'hED, ack: 1'b1, glitch: 1'b0, exp_code: 2'b00, exp_done: 1'b1};
        vecs[1] = '{cmd: 8'h00, ack: 1'b0, glitch: 1'b0, exp_code: 2'b01, exp_done: 1'b0};
        vecs[2] = '{cmd: 8'hFF, ack: 1'b1, glitch: 1'b1, exp_code: 2'b00, exp_done: 1'b1};
        vecs[3] = '{cmd: 8'h5A, ack: 1'b1, glitch: 1'b1, exp_code: 2'b00, exp_done: 1'b1};
        for (int i = 4; i < 9; i++) begin
            vecs[i].cmd      = 8'($urandom_range(0, 255));
            vecs[i].ack      = 1'($urandom_range(0, 1));
            vecs[i].glitch   = 1'($urandom_range(0, 1));
            vecs[i].exp_code = vecs[i].ack ? 2'b00 : 2'b01;
            vecs[i].exp_done = vecs[i].ack;
        end

        repeat (3) @(negedge clk);
        check("reset_ps2c_oe", ps2c_oe, 0);
        check("reset_ps2d_oe", ps2d_oe, 0);
        check("reset_rx_enable", rx_enable, 1);
        check("reset_pulses", {done, err}, 2'b00);
        check("reset_err_code", err_code, 2'b00);
        check("reset_cmd_ready", cmd_ready, 1);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            accept(vecs[i].cmd);
            finish_frame(vecs[i]);
            repeat (10) @(negedge clk);
        end

        // Device never clocks: err exactly TMO cycles after SHIFT entry.
        accept(8'h3C);
        e0 = err_cnt;
        k = 0;
        while (err !== 1'b1 && k < TMO + 20) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", k, TMO);
        check("timeout_err_code", err_code, 2'b10);
        @(negedge clk);
        check("timeout_oe_released", {ps2c_oe, ps2d_oe}, 2'b00);
        check("timeout_err_pulses", err_cnt - e0, 1);
        $display("[TB] timeout cmd=3c cycles=%0d code=%0d", k, err_code);
        repeat (10) @(negedge clk);

        // Offer while the receiver is busy, then release it.
        rx_busy = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 8'h81;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0 || rx_enable !== 1'b1) bad++;
        end
        check("blocked_while_rx_busy", bad, 0);
        rx_busy = 1'b0;
        #1 check("cmd_ready_when_rx_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rx_enable_low_after_late_accept", rx_enable, 0);
        measure_inhibit();
        finish_frame('{cmd: 8'h81, ack: 1'b1, glitch: 1'b0, exp_code: 2'b00, exp_done: 1'b1});
        repeat (10) @(negedge clk);

        // Asynchronous reset in the middle of SHIFT.
        accept(8'h00);
        device(4, 1'b0, 1'b0, bits);
        repeat (10) @(negedge clk);
        check("ps2d_oe_before_reset", ps2d_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ps2c_oe", ps2c_oe, 0);
        check("async_reset_ps2d_oe", ps2d_oe, 0);
        check("async_reset_err_code", err_code, 2'b00);
        check("async_reset_rx_enable", rx_enable, 1);
        $display("[TB] mid-shift reset oe=%0d%0d rx_enable=%0d", ps2c_oe, ps2d_oe, rx_enable);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        accept(8'hAB);
        finish_frame('{cmd: 8'hAB, ack: 1'b1, glitch: 1'b0, exp_code: 2'b00, exp_done: 1'b1});

        check("done_err_never_together", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
